// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data
// requesters. One transaction in flight; data port wins unless fetch has
// been starved for STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstd,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_wren,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic {
        IDLE,
        RD
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = 2;
    localparam logic [LW-1:0] LAT_LOAD  = LW'(LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        r_state;
    state_t        w_next_state;
    logic [LW-1:0] r_lat;
    logic [SW-1:0] r_starve;
    owner_t        r_owner;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_if_rvalid;
    logic          r_dm_rvalid;

    logic          w_force;
    logic          w_if_win;
    logic          w_dm_win;
    logic          w_read_grant;
    logic          w_rd_done;

    assign w_read_grant = w_if_win | (w_dm_win & ~dm_we);
    assign w_rd_done    = (r_state == RD) && (r_lat == '0);

    // State register; reset discards any in-flight read.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: reads occupy RD until the latency counter expires; writes stay in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_read_grant) w_next_state = RD;
            RD:      if (r_lat == '0)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: grant selection in IDLE and memory strobe mux from the winner.
    always_comb begin
        w_force  = if_req && (r_starve == STARVE_LIM);
        w_dm_win = 1'b0;
        w_if_win = 1'b0;
        // Grants are gated by rstd so nothing strobes while reset is held.
        if ((r_state == IDLE) && !rstd) begin
            if (dm_req && !w_force) begin
                w_dm_win = 1'b1;
            end else if (if_req) begin
                w_if_win = 1'b1;
            end
        end
        if_gnt    = w_if_win;
        dm_gnt    = w_dm_win;
        mem_en    = w_if_win | w_dm_win;
        mem_we    = w_dm_win & dm_we;
        mem_be    = w_dm_win ? dm_wren : (w_if_win ? 4'b1111 : 4'b0000);
        mem_addr  = w_dm_win ? dm_addr : (w_if_win ? if_addr : '0);
        mem_wdata = w_dm_win ? dm_wdata : '0;
        busy      = (r_state == RD);
    end

    // Latency counter and read owner, loaded on a read grant.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_lat   <= '0;
            r_owner <= OWN_NONE;
        end else if (w_read_grant) begin
            r_lat   <= LAT_LOAD;
            r_owner <= w_if_win ? OWN_IF : OWN_DM;
        end else if (r_state == RD) begin
            if (r_lat != '0) begin
                r_lat <= r_lat - LW'(1);
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

    // Read return: capture memory data for the owner and pulse its rvalid next cycle.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_rd_done && (r_owner == OWN_IF);
            r_dm_rvalid <= w_rd_done && (r_owner == OWN_DM);
            if (w_rd_done && (r_owner == OWN_IF)) r_if_rdata <= mem_rdata;
            if (w_rd_done && (r_owner == OWN_DM)) r_dm_rdata <= mem_rdata;
        end
    end

    // Starvation counter: counts data grants that overtook a pending fetch.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_starve <= '0;
        end else if (!if_req || w_if_win) begin
            r_starve <= '0;
        end else if (w_dm_win && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign dm_rvalid = r_dm_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a grant/read-data scoreboard.
// One instance uses LAT=1, a second uses LAT=3 for the reset-during-read case.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- LAT=1 instance signals ----------------
    logic        rstd;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_wren;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    // ---------------- LAT=3 instance signals ----------------
    logic        l3_rstd;
    logic        l3_if_req, l3_if_gnt, l3_if_rvalid;
    logic [7:0]  l3_if_addr;
    logic [31:0] l3_if_rdata;
    logic        l3_dm_req, l3_dm_we, l3_dm_gnt, l3_dm_rvalid;
    logic [3:0]  l3_dm_wren;
    logic [7:0]  l3_dm_addr;
    logic [31:0] l3_dm_wdata, l3_dm_rdata;
    logic        l3_mem_en, l3_mem_we, l3_busy;
    logic [3:0]  l3_mem_be;
    logic [7:0]  l3_mem_addr;
    logic [31:0] l3_mem_wdata, l3_mem_rdata;

    mem_arbiter #(.AW(8), .DW(32), .LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rstd(rstd),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wren(dm_wren), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(8), .DW(32), .LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rstd(l3_rstd),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt),
        .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
        .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_wren(l3_dm_wren), .dm_addr(l3_dm_addr),
        .dm_wdata(l3_dm_wdata), .dm_gnt(l3_dm_gnt), .dm_rvalid(l3_dm_rvalid), .dm_rdata(l3_dm_rdata),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_be(l3_mem_be), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem1 [256] = '{default: '0};
    logic [31:0] mem3 [256] = '{default: '0};
    logic [31:0] rd1 = '0;
    logic [31:0] p3 [3] = '{default: '0};
    logic        ld_en = 1'b0;
    logic [7:0]  ld_a  = '0;
    logic [31:0] ld_d  = '0;

    // Memory with one-cycle read latency, byte-enabled writes, and a preload port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem1[ld_a] <= ld_d;
            mem3[ld_a] <= ld_d;
        end
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem1[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd1 <= (mem_en && !mem_we) ? mem1[mem_addr] : 32'h0;
    end
    assign mem_rdata = rd1;

    // Memory with three-cycle read latency for the second instance.
    always @(posedge clk) begin
        p3[0] <= (l3_mem_en && !l3_mem_we) ? mem3[l3_mem_addr] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign l3_mem_rdata = p3[2];

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         is_if;
        logic [7:0] addr;
    } gnt_t;

    gnt_t        gq[$];
    logic [31:0] ifq[$];
    logic [31:0] dmq[$];
    logic [31:0] ifq3[$];

    function automatic gnt_t mk(input bit is_if, input logic [7:0] a);
        gnt_t g;
        g.is_if = is_if;
        g.addr  = a;
        return g;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor for the LAT=1 instance: grants and read data against the queues.
    always @(negedge clk) begin
        gnt_t e;
        if (if_gnt || dm_gnt) begin
            chk("gnt_onehot", {31'b0, if_gnt ^ dm_gnt}, 32'd1);
            chk("gnt_while_busy", {31'b0, busy}, 32'd0);
            chk("gnt_mem_en", {31'b0, mem_en}, 32'd1);
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {30'b0, if_gnt, dm_gnt}, 32'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt_port_is_if", {31'b0, if_gnt}, {31'b0, e.is_if});
                chk("gnt_addr", {24'b0, mem_addr}, {24'b0, e.addr});
            end
        end else begin
            chk("idle_strobes", {30'b0, mem_en, mem_we}, 32'd0);
        end
        if (if_rvalid) begin
            if (ifq.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
            else                 chk("if_rdata", if_rdata, ifq.pop_front());
        end
        if (dm_rvalid) begin
            if (dmq.size() == 0) chk("dm_rvalid_unexpected", {31'b0, dm_rvalid}, 32'd0);
            else                 chk("dm_rdata", dm_rdata, dmq.pop_front());
        end
    end

    // Monitor for the LAT=3 instance.
    always @(negedge clk) begin
        if (l3_if_gnt || l3_dm_gnt)
            chk("l3_gnt_while_busy", {31'b0, l3_busy}, 32'd0);
        if (l3_if_rvalid) begin
            if (ifq3.size() == 0) chk("l3_if_rvalid_unexpected", {31'b0, l3_if_rvalid}, 32'd0);
            else                  chk("l3_if_rdata", l3_if_rdata, ifq3.pop_front());
        end
        if (l3_dm_rvalid)
            chk("l3_dm_rvalid_unexpected", {31'b0, l3_dm_rvalid}, 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        step;
        ld_en = 1'b0;
    endtask

    // Both ports request reads continuously; every fifth grant goes to fetch.
    task automatic contend(input int n);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 8'h30;
        if_req  = 1'b1;
        if_addr = 8'h20;
        for (int k = 0; k < n; k++) begin
            if ((k % 5) == 4) begin
                gq.push_back(mk(1'b1, 8'h20));
                ifq.push_back(32'hA5A50020);
            end else begin
                gq.push_back(mk(1'b0, 8'h30));
                dmq.push_back(32'h5A5A0030);
            end
        end
        repeat (2 * n - 1) step;
        dm_req = 1'b0;
        if_req = 1'b0;
        step;
        step;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstd = 1'b1; l3_rstd = 1'b1;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_wren = '0; dm_addr = '0; dm_wdata = '0;
        l3_if_req = 0; l3_if_addr = '0; l3_dm_req = 0; l3_dm_we = 0;
        l3_dm_wren = '0; l3_dm_addr = '0; l3_dm_wdata = '0;

        preload(8'h04, 32'h20010005);
        preload(8'h20, 32'hA5A50020);
        preload(8'h30, 32'h5A5A0030);

        // Reset state
        samp;
        chk("rst_strobes", {25'b0, if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        step;
        rstd = 1'b0; l3_rstd = 1'b0;
        step;

        // Single fetch read, LAT=1
        step;
        if_req = 1'b1; if_addr = 8'h04;
        gq.push_back(mk(1'b1, 8'h04));
        ifq.push_back(32'h20010005);
        samp; chk("t1_if_gnt", {31'b0, if_gnt}, 32'd1);
              chk("t1_be", {28'b0, mem_be}, 32'hF);
        step; if_req = 1'b0;
        samp; chk("t1_busy_c1", {31'b0, busy}, 32'd1);
              chk("t1_rvalid_c1", {31'b0, if_rvalid}, 32'd0);
        step;
        samp; chk("t1_busy_c2", {31'b0, busy}, 32'd0);
              chk("t1_rvalid_c2", {31'b0, if_rvalid}, 32'd1);

        // Partial write then read-back
        step;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF; dm_wren = 4'b0011;
        gq.push_back(mk(1'b0, 8'h10));
        samp; chk("t2_wr_gnt", {31'b0, dm_gnt}, 32'd1);
              chk("t2_wr_be", {28'b0, mem_be}, 32'h3);
              chk("t2_wr_we", {31'b0, mem_we}, 32'd1);
              chk("t2_wr_wdata", mem_wdata, 32'hDEADBEEF);
        step;
        dm_we = 1'b0; dm_wren = 4'b0000;
        gq.push_back(mk(1'b0, 8'h10));
        dmq.push_back(32'h0000BEEF);
        samp; chk("t2_rd_gnt", {31'b0, dm_gnt}, 32'd1);
              chk("t2_rd_we", {31'b0, mem_we}, 32'd0);
        step; dm_req = 1'b0;
        samp;
        step;
        samp; chk("t2_rvalid", {31'b0, dm_rvalid}, 32'd1);

        // Sustained contention: dm,dm,dm,dm,if repeating
        step;
        contend(10);

        // Simultaneous requests with a data write
        step;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h40; dm_wdata = 32'h11223344; dm_wren = 4'b1111;
        if_req = 1'b1; if_addr = 8'h04;
        gq.push_back(mk(1'b0, 8'h40));
        gq.push_back(mk(1'b1, 8'h04));
        ifq.push_back(32'h20010005);
        samp; chk("t5_first", {30'b0, if_gnt, dm_gnt}, 32'h1);
        step; dm_req = 1'b0; dm_we = 1'b0;
        samp; chk("t5_second", {30'b0, if_gnt, dm_gnt}, 32'h2);
        step; if_req = 1'b0;
        samp; chk("t5_rvalid_c2", {31'b0, if_rvalid}, 32'd0);
        step;
        samp; chk("t5_rvalid_c3", {31'b0, if_rvalid}, 32'd1);

        // Fetch request pulsed and withdrawn while a read is outstanding
        step;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10;
        gq.push_back(mk(1'b0, 8'h10));
        dmq.push_back(32'h0000BEEF);
        samp; chk("t6_dm_gnt", {31'b0, dm_gnt}, 32'd1);
        step; dm_req = 1'b0; if_req = 1'b1; if_addr = 8'h20;
        samp; chk("t6_no_if_gnt", {30'b0, if_gnt, mem_en}, 32'd0);
        step; if_req = 1'b0;
        samp; chk("t6_idle_en", {31'b0, mem_en}, 32'd0);
              chk("t6_rvalid", {31'b0, dm_rvalid}, 32'd1);
        step;
        // A starve count still at zero means four data grants precede fetch.
        contend(5);

        // LAT=3 read interrupted by reset
        step;
        l3_if_req = 1'b1; l3_if_addr = 8'h04;
        samp; chk("t4_gnt", {31'b0, l3_if_gnt}, 32'd1);
              chk("t4_addr", {24'b0, l3_mem_addr}, 32'h04);
        step; l3_if_req = 1'b0;
        samp; chk("t4_busy", {31'b0, l3_busy}, 32'd1);
        step;
        l3_rstd = 1'b1; l3_if_req = 1'b1; l3_dm_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            samp;
            chk("t4_rst_strobes", {25'b0, l3_if_gnt, l3_dm_gnt, l3_mem_en, l3_mem_we,
                                   l3_busy, l3_if_rvalid, l3_dm_rvalid}, 32'd0);
            chk("t4_rst_be", {28'b0, l3_mem_be}, 32'd0);
            chk("t4_rst_rdata", l3_if_rdata | l3_dm_rdata, 32'd0);
            step;
        end
        l3_rstd = 1'b0; l3_if_req = 1'b0; l3_dm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp;
            chk("t4_no_rvalid", {29'b0, l3_if_rvalid, l3_dm_rvalid, l3_busy}, 32'd0);
            step;
        end
        l3_if_req = 1'b1; l3_if_addr = 8'h04;
        ifq3.push_back(32'h20010005);
        samp; chk("t4_clean_gnt", {30'b0, l3_if_gnt, l3_dm_gnt}, 32'h2);
        step; l3_if_req = 1'b0;
        samp; chk("t4_clean_busy", {31'b0, l3_busy}, 32'd1);
        repeat (3) step;
        samp; chk("t4_clean_rvalid", {31'b0, l3_if_rvalid}, 32'd1);
        step;
        step;

        chk("gq_drained", gq.size(), 32'd0);
        chk("ifq_drained", ifq.size(), 32'd0);
        chk("dmq_drained", dmq.size(), 32'd0);
        chk("ifq3_drained", ifq3.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
